// File: rtl/uart_pkg.sv
// Shared UART constants and FSM state encoding, used by the transmitter and the matching receiver.
package uart_pkg;

  localparam int UART_DATA_W     = 7;
  localparam int UART_FRAME_BITS = 10;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Odd parity: XOR of data plus parity bit equals 1.
  function automatic logic odd_parity(input logic [UART_DATA_W-1:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and pulses o_done on the last count.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_done
);

  localparam int               CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_done = i_en && (r_cnt == LAST);

  // Restarting on o_done clears the count at every bit boundary.
  always_ff @(posedge clk) begin
    if (!rst_n)              r_cnt <= '0;
    else if (!i_en || o_done) r_cnt <= '0;
    else                     r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/uart_tx.sv
// 7O1 UART transmitter: start, 7 data bits LSB first, odd parity, stop.
// Optional UART_TX_ERR_INJECT_EN adds parity/stop-bit error injection latched at accept.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [UART_DATA_W-1:0] tx_data,
  input  logic                   tx_valid,
`ifdef UART_TX_ERR_INJECT_EN
  input  logic                   inject_parity_err,
  input  logic                   inject_frame_err,
`endif
  output logic                   tx_ready,
  output logic                   tx,
  output logic                   busy
);

  localparam logic [2:0] LAST_IDX = 3'(UART_DATA_W - 1);

  uart_state_e            r_state, w_state_next;
  logic [2:0]             r_bit_idx, w_bit_idx_next;
  logic [UART_DATA_W-1:0] r_data;
  logic                   r_par, r_stop, r_tx;
  logic                   w_tx_next, w_bit_done, w_accept;
  logic                   w_par_in, w_stop_in;

  assign w_accept = tx_valid && (r_state == ST_IDLE);

`ifdef UART_TX_ERR_INJECT_EN
  assign w_par_in  = odd_parity(tx_data) ^ inject_parity_err;
  assign w_stop_in = inject_frame_err ? ~STOP_BIT : STOP_BIT;
`else
  assign w_par_in  = odd_parity(tx_data);
  assign w_stop_in = STOP_BIT;
`endif

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (r_state != ST_IDLE),
    .o_done (w_bit_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_bit_idx <= '0;
      r_data    <= '0;
      r_par     <= 1'b0;
      r_stop    <= STOP_BIT;
      r_tx      <= IDLE_LEVEL;
    end else begin
      r_state   <= w_state_next;
      r_bit_idx <= w_bit_idx_next;
      r_tx      <= w_tx_next;
      if (w_accept) begin
        r_data <= tx_data;
        r_par  <= w_par_in;
        r_stop <= w_stop_in;
      end
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_bit_idx_next = r_bit_idx;
    unique case (r_state)
      ST_IDLE: if (tx_valid) begin
        w_state_next   = ST_START;
        w_bit_idx_next = '0;
      end
      ST_START:  if (w_bit_done) w_state_next = ST_DATA;
      ST_DATA: if (w_bit_done) begin
        if (r_bit_idx == LAST_IDX) begin
          w_state_next   = ST_PARITY;
          w_bit_idx_next = '0;
        end else begin
          w_bit_idx_next = r_bit_idx + 3'd1;
        end
      end
      ST_PARITY: if (w_bit_done) w_state_next = ST_STOP;
      ST_STOP:   if (w_bit_done) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Line level is decoded from the next state so tx changes on the same edge as the state.
  always_comb begin
    w_tx_next = IDLE_LEVEL;
    unique case (w_state_next)
      ST_START:  w_tx_next = START_BIT;
      ST_DATA:   w_tx_next = r_data[w_bit_idx_next];
      ST_PARITY: w_tx_next = r_par;
      ST_STOP:   w_tx_next = r_stop;
      default:   w_tx_next = IDLE_LEVEL;
    endcase
  end

  assign tx       = r_tx;
  assign tx_ready = (r_state == ST_IDLE);
  assign busy     = ~tx_ready;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx (CLKS_PER_BIT=4): directed and random frames against a frame model.
module tb_uart_tx;

  localparam int CPB = 4;
  localparam int FRAME_CYC = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [6:0] tx_data = '0;
  logic       tx, tx_ready, busy;
`ifdef UART_TX_ERR_INJECT_EN
  logic       inject_parity_err = 1'b0;
  logic       inject_frame_err = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
`ifdef UART_TX_ERR_INJECT_EN
    .inject_parity_err (inject_parity_err),
    .inject_frame_err  (inject_frame_err),
`endif
    .tx_ready          (tx_ready),
    .tx                (tx),
    .busy              (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line levels of one frame, index 0 = first bit on the wire.
  function automatic logic [9:0] frame_bits(input logic [6:0] d, input bit perr, input bit ferr);
    logic [9:0] f;
    int ones;
    ones = 0;
    for (int i = 0; i < 7; i++) ones += int'(d[i]);
    f[0]   = 1'b0;
    f[7:1] = d;
    f[8]   = ((ones % 2) == 0) ? 1'b1 : 1'b0;
    if (perr) f[8] = ~f[8];
    f[9]   = ferr ? 1'b0 : 1'b1;
    return f;
  endfunction

  // Entered at the negedge just after the accept edge; leaves at the idle gap cycle.
  task automatic check_frame(input logic [6:0] d, input bit perr, input bit ferr, input bit junk);
    logic [9:0] f;
    f = frame_bits(d, perr, ferr);
    for (int k = 0; k < FRAME_CYC; k++) begin
      chk($sformatf("tx d=%02h bit%0d cyc%0d", d, k / CPB, k % CPB), 32'(tx), 32'(f[k / CPB]));
      chk($sformatf("ready_busy d=%02h cyc%0d", d, k), 32'({tx_ready, busy}), 32'b01);
      if (junk) begin
        tx_valid = (k < FRAME_CYC - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        tx_data  = 7'($urandom);
      end
      @(negedge clk);
    end
    chk($sformatf("gap_tx d=%02h", d), 32'(tx), 32'd1);
    chk($sformatf("gap_ready d=%02h", d), 32'({tx_ready, busy}), 32'b10);
  endtask

  task automatic send(input logic [6:0] d, input bit perr, input bit ferr, input bit junk);
    chk("ready_before_send", 32'(tx_ready), 32'd1);
    tx_valid = 1'b1;
    tx_data  = d;
`ifdef UART_TX_ERR_INJECT_EN
    inject_parity_err = perr;
    inject_frame_err  = ferr;
`endif
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 7'($urandom);
`ifdef UART_TX_ERR_INJECT_EN
    inject_parity_err = 1'b0;
    inject_frame_err  = 1'b0;
`endif
    check_frame(d, perr, ferr, junk);
  endtask

  initial begin
    logic [9:0] fz;
    int gap;

    // Reset with tx_valid held high: must stay idle and not accept.
    rst_n = 1'b0; tx_valid = 1'b1; tx_data = 7'h41;
    repeat (3) begin
      @(negedge clk);
      chk("reset_idle", 32'({tx, tx_ready, busy}), 32'b110);
    end
    tx_valid = 1'b0; rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_reset_idle", 32'({tx, tx_ready, busy}), 32'b110);
    end

    send(7'h41, 1'b0, 1'b0, 1'b0);
    send(7'h07, 1'b0, 1'b0, 1'b0);

    // Back-to-back with tx_valid held and data changed mid-frame.
    tx_valid = 1'b1; tx_data = 7'h55;
    @(negedge clk);
    tx_data = 7'h2A;
    check_frame(7'h55, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tx_valid = 1'b0;
    check_frame(7'h2A, 1'b0, 1'b0, 1'b0);

    // Random characters, random idle gaps, junk on the inputs while busy.
    for (int n = 0; n < 12; n++) begin
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        chk("idle_gap_tx", 32'(tx), 32'd1);
        @(negedge clk);
      end
      send(7'($urandom), 1'b0, 1'b0, 1'b1);
    end

    // Reset on the 15th edge of a frame of zeros: line goes idle and stays there.
    fz = frame_bits(7'h00, 1'b0, 1'b0);
    tx_valid = 1'b1; tx_data = 7'h00;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int k = 0; k < 15; k++) begin
      chk($sformatf("pre_abort_tx cyc%0d", k), 32'(tx), 32'(fz[k / CPB]));
      if (k == 14) rst_n = 1'b0;
      @(negedge clk);
    end
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_ready", 32'({tx_ready, busy}), 32'b10);
    rst_n = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      chk($sformatf("post_abort cyc%0d", k), 32'({tx, tx_ready}), 32'b11);
    end

`ifdef UART_TX_ERR_INJECT_EN
    send(7'h41, 1'b1, 1'b0, 1'b0);
    send(7'h41, 1'b0, 1'b1, 1'b0);
    send(7'h41, 1'b0, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter: CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200 baud); SHALL be >= 2.
REQ-002 Port: clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 Port: tx_data  input  7  character to send; sampled only on accept.
REQ-005 Port: tx_valid  input  1  request to send tx_data.
REQ-006 Port: tx_ready  output  1  block idle, can accept a character.
REQ-007 Port: tx  output  1  serial line; idle high.
REQ-008 Port: busy  output  1  frame in progress (inverse of tx_ready).

Function
REQ-009 Frame SHALL be 10 bits: start (0), 7 data bits LSB first, parity, stop (1).
REQ-010 Parity bit SHALL be odd parity: XOR of all 7 data bits plus the parity bit = 1, so parity = ~^tx_data.
REQ-011 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-012 Accept SHALL occur on a clock edge with tx_valid=1 and tx_ready=1; tx_data and parity are latched on that edge, and the state goes IDLE->START.
REQ-013 tx SHALL drive the start bit from the cycle after the accept edge.
REQ-014 Each bit SHALL last exactly CLKS_PER_BIT cycles, timed by a baud counter counting 0..CLKS_PER_BIT-1 (width $clog2(CLKS_PER_BIT)).
REQ-015 The baud counter SHALL clear on every state/bit change.
REQ-016 A 3-bit index SHALL select the data bits 0..6.
REQ-017 DATA SHALL go to PARITY after bit 6 completes.
REQ-018 STOP SHALL go to IDLE after CLKS_PER_BIT cycles.
REQ-019 tx_ready SHALL be 1 only in IDLE; busy = ~tx_ready.
REQ-020 Back-to-back frames SHALL repeat every 10*CLKS_PER_BIT+1 cycles, with one idle-high cycle between the stop bit and the next start bit.
REQ-021 tx_valid and tx_data changes while busy SHALL be ignored; the latched character is sent unaltered.
REQ-022 tx SHALL be registered and glitch-free, with no combinational path from any input to tx.

Reset
REQ-023 rst_n=0 at a clock edge SHALL give: state IDLE, tx=1, tx_ready=1, busy=0, counters 0, data register 0.
REQ-024 Reset mid-frame SHALL abort the frame: tx=1 from the edge that samples rst_n=0, and the aborted character is never resumed.
REQ-025 tx_valid asserted during reset SHALL NOT be accepted.

Configuration
REQ-026 Macro UART_TX_ERR_INJECT_EN, when defined, SHALL add inputs inject_parity_err (1) and inject_frame_err (1), sampled at accept.
REQ-027 With inject_parity_err latched high, the parity bit SHALL be inverted for that frame.
REQ-028 With inject_frame_err latched high, the stop bit SHALL be driven 0 for that frame.
REQ-029 Without the macro, the injection ports and logic SHALL be absent and the frames always correct.

Structure
REQ-030 Shared package/header uart_pkg SHALL hold the FSM state encodings, UART_DATA_W=7, UART_FRAME_BITS=10, START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1; the matching receiver uses the same constants.
REQ-031 A sub-module uart_baud_tick (counter and bit-done pulse, parameter CLKS_PER_BIT) SHALL be used and is reusable by the receiver.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-032 Send tx_data=7'h41 -> tx bit sequence 0,1,0,0,0,0,0,1,1,1 with each bit 4 cycles long, and parity=1.
REQ-033 Send tx_data=7'h07 -> parity bit 0; frame 0,1,1,1,0,0,0,0,0,1; tx_ready low for exactly 40 cycles.
REQ-034 Hold tx_valid high with 7'h55 then 7'h2A -> two frames with start-bit edges 41 cycles apart; data changed mid-frame has no effect.
REQ-035 Assert rst_n=0 at cycle 15 of a frame -> tx=1 and tx_ready=1 on that edge, and no further low bits appear.
REQ-036 With UART_TX_ERR_INJECT_EN, send 7'h41 with inject_parity_err=1 -> parity bit 0; loopback into the team receiver gives parity_error=1 and framing_error=0.
REQ-037 With UART_TX_ERR_INJECT_EN, send 7'h41 with inject_frame_err=1 -> stop bit 0; the receiver gives framing_error=1.
